// File: rtl/sum_pkg.sv
// Shared types for the sum result buffer.
// Entries carry the split nibble pair and the status code.
package sum_pkg;

  localparam int SUM_W = 8;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } nibble_pair_t;

  typedef enum logic [1:0] {
    ST_ZERO    = 2'd0,
    ST_MAX     = 2'd1,
    ST_OTHER   = 2'd2,
    ST_ILLEGAL = 2'd3
  } status_e;

  typedef struct packed {
    nibble_pair_t pair;
    status_e      st;
  } entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sum_result_buffer.sv
// Buffers {sum, status} samples in a show-ahead FIFO and keeps
// saturating per-class statistics plus a sticky overflow flag.
module sum_result_buffer
  import sum_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [SUM_W-1:0]         in_sum,
  input  logic [1:0]               in_status,
  input  logic                     out_ready,
  input  logic                     clr_stats,
  output logic                     out_valid,
  output logic [3:0]               out_x,
  output logic [3:0]               out_y,
  output logic [1:0]               out_status,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         cnt_zero,
  output logic [CNT_W-1:0]         cnt_max,
  output logic [CNT_W-1:0]         cnt_other,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_ovf;

  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  entry_t          w_in;
  entry_t          w_head;

  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves the same cycle.
  assign w_push = in_valid && (!w_full || w_pop);
  assign w_drop = in_valid && w_full && !w_pop;

  assign w_in.pair.x = in_sum[3:0];
  assign w_in.pair.y = in_sum[7:4];
  assign w_in.st     = status_e'(in_status);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (clr_stats) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign out_valid  = (r_level != '0);
  assign out_x      = out_valid ? w_head.pair.x : 4'h0;
  assign out_y      = out_valid ? w_head.pair.y : 4'h0;
  assign out_status = out_valid ? 2'(w_head.st) : 2'b00;
  assign level      = r_level;
  assign overflow   = r_ovf;

  // Dropped samples are still counted by class.
  sat_counter #(.W(CNT_W)) u_cnt_zero (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats),
    .inc   (in_valid && (in_status == 2'b00)),
    .q     (cnt_zero)
  );

  sat_counter #(.W(CNT_W)) u_cnt_max (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats),
    .inc   (in_valid && (in_status == 2'b01)),
    .q     (cnt_max)
  );

  sat_counter #(.W(CNT_W)) u_cnt_other (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats),
    .inc   (in_valid && in_status[1]),
    .q     (cnt_other)
  );

endmodule

// File: doc/sum_result_buffer.md
Name: sum_result_buffer

Overview:
- Downstream consumer of the adder/status stage.
- Captures each valid {sum, status} sample and splits sum into a packed nibble-pair struct {x = sum[3:0], y = sum[7:4]}.
- Buffers samples in a small show-ahead FIFO built as an unpacked array of structs, drained through a valid/ready interface.
- Keeps saturating per-class statistics counters (zero / max / other) and a sticky overflow flag, for the Verilator C++ harness to read.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 8, width of each statistics counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  sample present this cycle; no upstream backpressure
in_sum  in  8  registered sum from upstream stage
in_status  in  2  00 zero, 01 max, 10 other, 11 illegal
out_ready  in  1  downstream accepts head entry
clr_stats  in  1  synchronous clear of counters and overflow
out_valid  out  1  FIFO non-empty
out_x  out  4  head entry sum[3:0]
out_y  out  4  head entry sum[7:4]
out_status  out  2  head entry status
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
cnt_zero  out  CNT_W  samples with status 00
cnt_max  out  CNT_W  samples with status 01
cnt_other  out  CNT_W  samples with status 10 or 11
overflow  out  1  sticky: a sample was dropped

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr and level go to 0; out_valid = 0.
  - All counters = 0; overflow = 0.
  - Memory array is not reset.
- Push:
  - Occurs when in_valid && !full, or when in_valid && full && pop in the same cycle.
  - Writes entry {x, y, status} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop:
  - Occurs when out_valid && out_ready; rd_ptr wraps modulo DEPTH.
  - out_ready while empty has no effect.
- Show-ahead output:
  - out_valid = (level != 0).
  - out_x, out_y and out_status come from mem[rd_ptr] and are forced to 0 while out_valid = 0.
  - Latency: a sample pushed in cycle N is visible at the head in cycle N+1 when the FIFO was empty. No combinational in-to-out path.
- Level:
  - +1 on push only, -1 on pop only, unchanged on push+pop.
- Full drop:
  - in_valid && full && !pop: sample discarded, FIFO unchanged, overflow set to 1 next cycle.
  - overflow stays 1 until clr_stats or reset.
- Push+pop while full: both occur; no drop; level stays DEPTH.
- Push+pop while empty: push only (pop requires out_valid); level becomes 1.
- Statistics:
  - Every in_valid sample increments its class counter, including dropped samples.
  - Status 11 counts as other and is stored unchanged.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- clr_stats:
  - Next cycle all counters = 0 and overflow = 0; the same-cycle sample is not counted.
  - Clear has priority over increment and over overflow set.
  - FIFO contents and pointers are unaffected.
- Reset mid-operation: all buffered entries are discarded immediately (level = 0, out_valid = 0 asynchronously).

Decomposition:
- Package sum_pkg holds:
  - nibble_pair_t: struct packed {logic [3:0] x, y;}
  - status_e: enum logic [1:0] {ST_ZERO=0, ST_MAX=1, ST_OTHER=2, ST_ILLEGAL=3}
  - entry_t: struct packed {nibble_pair_t pair; status_e st;}
  - SUM_W = 8
- Sub-module sat_counter (params W; ports clk, rst_n, clr, inc, q), instantiated three times.
- FIFO storage is inline: entry_t mem [DEPTH].

Test Plan:
- Reset, then in_valid=1, sum=8'h3C, status=10 for one cycle, out_ready=0 -> next cycle out_valid=1, out_x=4'hC, out_y=4'h3, out_status=10, level=1, cnt_other=1.
- Push 4 samples (8'h00/00, 8'hFF/01, 8'h12/10, 8'h34/10), then assert out_ready -> entries pop in order; level 4->0; cnt_zero=1, cnt_max=1, cnt_other=2; out fields read 0 once empty.
- With the FIFO full and out_ready=0, push 8'h55/10 -> dropped, level=4, overflow=1, cnt_other increments; then the same push with out_ready=1 -> accepted, level stays 4, head advances.
- Drive 300 samples with status 00 while CNT_W=8 -> cnt_zero holds 255; clr_stats together with in_valid -> cnt_zero=0 and overflow=0 next cycle.
- Assert rst_n=0 mid-stream with level=3 -> out_valid=0, level=0 without waiting for a clock edge; after release the first new sample appears after 1 cycle.
- Push status 11 with sum 8'hA5 -> stored with out_status=11, cnt_other increments, no other counter changes.
